// File: rtl/mem_arb.sv
// Arbiter/sequencer for the shared single-port memory.
// CPU and debug/loader requesters; bounded CPU burst and access timeout.
module mem_arb #(
  parameter int MAX_CPU_BURST = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int BW = $clog2(MAX_CPU_BURST + 1) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [BW-1:0] MAXB  = BW'(MAX_CPU_BURST);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   crd_q, crd_d;
  logic [31:0]   drd_q, drd_d;
  logic          cack_q, cack_d;
  logic          dack_q, dack_d;
  logic          err_q, err_d;
  logic          gnt_cpu, gnt_dbg;

  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dbg = 1'b0;
    state_d = state_q;
    burst_d = burst_q;
    wait_d  = wait_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    crd_d   = crd_q;
    drd_d   = drd_q;
    cack_d  = 1'b0;
    dack_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          cpu_req && dbg_req: begin
            if (burst_q == MAXB) begin
              gnt_dbg = 1'b1;
            end else begin
              gnt_cpu = 1'b1;
              burst_d = burst_q + 1'b1;
            end
          end
          cpu_req && !dbg_req: begin
            gnt_cpu = 1'b1;
            burst_d = '0;
          end
          !cpu_req && dbg_req: gnt_dbg = 1'b1;
          default: ;
        endcase
        if (gnt_dbg) burst_d = '0;
        if (gnt_cpu) begin
          state_d = CPU;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
        end else if (gnt_dbg) begin
          state_d = DBG;
          we_d    = dbg_we;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
        end
      end
      CPU, DBG: begin
        if (mem_ready) begin
          state_d = IDLE;
          wait_d  = '0;
          if (state_q == CPU) begin
            crd_d  = mem_rdata;
            cack_d = 1'b1;
          end else begin
            drd_d  = mem_rdata;
            dack_d = 1'b1;
          end
        end else if (wait_q == TLAST) begin
          // Hung access: ack without data so the requester can move on
          state_d = IDLE;
          wait_d  = '0;
          err_d   = 1'b1;
          cack_d  = (state_q == CPU);
          dack_d  = (state_q == DBG);
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      burst_q <= '0;
      wait_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      drd_q   <= '0;
      cack_q  <= 1'b0;
      dack_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
      cack_q  <= cack_d;
      dack_q  <= dack_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = crd_q;
  assign dbg_rdata = drd_q;
  assign cpu_ack   = cack_q;
  assign dbg_ack   = dack_q;
  assign err       = err_q;
  assign cpu_stall = cpu_req & ~cack_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: two instances (burst 4/timeout 8 and
// burst 0/timeout 64) driven by the same requester and memory stimulus.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;

  logic [31:0] a_crd, a_drd, a_maddr, a_mwd;
  logic        a_cack, a_stall, a_dack, a_mreq, a_mwe, a_err;
  logic [31:0] b_crd, b_drd, b_maddr, b_mwd;
  logic        b_cack, b_stall, b_dack, b_mreq, b_mwe, b_err;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arb #(.MAX_CPU_BURST(4), .TIMEOUT(8)) u_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_crd), .cpu_ack(a_cack), .cpu_stall(a_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(a_drd), .dbg_ack(a_dack),
    .mem_req(a_mreq), .mem_we(a_mwe),
    .mem_addr(a_maddr), .mem_wdata(a_mwd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(a_err)
  );

  mem_arb #(.MAX_CPU_BURST(0), .TIMEOUT(64)) u_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_crd), .cpu_ack(b_cack), .cpu_stall(b_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(b_drd), .dbg_ack(b_dack),
    .mem_req(b_mreq), .mem_we(b_mwe),
    .mem_addr(b_maddr), .mem_wdata(b_mwd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    tick();
    // reset values, stall follows cpu_req even in reset
    chk("rst_mreq", 32'(a_mreq), 32'd0);
    chk("rst_cack", 32'(a_cack), 32'd0);
    chk("rst_dack", 32'(a_dack), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_addr", a_maddr, 32'd0);
    chk("rst_crd", a_crd, 32'd0);
    cpu_req = 1'b1;
    #1;
    chk("rst_stall", 32'(a_stall), 32'd1);
    cpu_req = 1'b0;
    rst = 1'b1;
    tick();

    // zero-wait CPU read
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    chk("rd_c0_stall", 32'(a_stall), 32'd1);
    chk("rd_c0_mreq", 32'(a_mreq), 32'd0);
    tick();
    chk("rd_c1_mreq", 32'(a_mreq), 32'd1);
    chk("rd_c1_addr", a_maddr, 32'h10);
    chk("rd_c1_we", 32'(a_mwe), 32'd0);
    chk("rd_c1_stall", 32'(a_stall), 32'd1);
    chk("rd_c1_ack", 32'(a_cack), 32'd0);
    tick();
    chk("rd_c2_ack", 32'(a_cack), 32'd1);
    chk("rd_c2_rdata", a_crd, 32'h1234_5678);
    chk("rd_c2_mreq", 32'(a_mreq), 32'd0);
    chk("rd_c2_stall", 32'(a_stall), 32'd0);
    chk("rd_c2_err", 32'(a_err), 32'd0);
    cpu_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    chk("rd_c3_ack", 32'(a_cack), 32'd0);

    // debug write, 3-cycle memory, requester inputs change mid-access
    dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 32'h40; dbg_wdata = 32'hCAFE_BABE;
    tick();
    dbg_addr = 32'hFFFF_0000; dbg_wdata = 32'h0; dbg_we = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("wr_mreq", 32'(a_mreq), 32'd1);
      chk("wr_we", 32'(a_mwe), 32'd1);
      chk("wr_addr", a_maddr, 32'h40);
      chk("wr_wdata", a_mwd, 32'hCAFE_BABE);
      chk("wr_dack_early", 32'(a_dack), 32'd0);
      if (c == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0055;
      end
      tick();
    end
    chk("wr_dack", 32'(a_dack), 32'd1);
    chk("wr_cack", 32'(a_cack), 32'd0);
    chk("wr_err", 32'(a_err), 32'd0);
    chk("wr_mreq_drop", 32'(a_mreq), 32'd0);
    chk("wr_crd_kept", a_crd, 32'h1234_5678);
    dbg_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    chk("wr_dack_1cyc", 32'(a_dack), 32'd0);

    // timeout: 8 cycles in CPU, then ack+err, rdata untouched
    mem_rdata = 32'hDEAD_BEEF;
    cpu_req = 1'b1; cpu_addr = 32'h80;
    tick();
    cpu_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("to_mreq", 32'(a_mreq), 32'd1);
      chk("to_ack_early", 32'(a_cack), 32'd0);
      tick();
    end
    chk("to_ack", 32'(a_cack), 32'd1);
    chk("to_err", 32'(a_err), 32'd1);
    chk("to_crd", a_crd, 32'h1234_5678);
    chk("to_idle", 32'(a_mreq), 32'd0);
    tick();
    chk("to_err_1cyc", 32'(a_err), 32'd0);

    // ties with both held, zero-wait
    do_reset();
    mem_ready = 1'b1;
    mem_rdata = 32'h0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h200;
    for (int g = 0; g < 10; g++) begin
      tick();
      chk("tie_a_addr", a_maddr, (g % 5 == 4) ? 32'h200 : 32'h100);
      chk("tie_b_addr", b_maddr, 32'h200);
      tick();
      chk("tie_a_cack", 32'(a_cack), (g % 5 == 4) ? 32'd0 : 32'd1);
      chk("tie_a_dack", 32'(a_dack), (g % 5 == 4) ? 32'd1 : 32'd0);
      chk("tie_b_dack", 32'(b_dack), 32'd1);
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    mem_ready = 1'b0;
    tick();

    // async reset while DBG is waiting on memory
    dbg_req = 1'b1; dbg_addr = 32'h300;
    tick();
    dbg_req = 1'b0;
    chk("ar_in_dbg", 32'(a_mreq), 32'd1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("ar_mreq_now", 32'(a_mreq), 32'd0);
    chk("ar_drd", a_drd, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("ar_no_dack1", 32'(a_dack), 32'd0);
    tick();
    chk("ar_no_dack2", 32'(a_dack), 32'd0);

    // fresh traffic after reset: burst count starts from zero
    cpu_req = 1'b1; cpu_addr = 32'h400;
    dbg_req = 1'b1; dbg_addr = 32'h500;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("post_addr", a_maddr, (g == 4) ? 32'h500 : 32'h400);
      tick();
      chk("post_cack", 32'(a_cack), (g == 4) ? 32'd0 : 32'd1);
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbiter and sequencer for the single-port unified memory of the multicycle CPU.
- Two requesters share the port:
  - the CPU port, driven by the multicycle controller in its IF and MEM states;
  - a debug/loader port used for program load and memory inspection.
- The block registers the winning request and holds it on the memory until the memory's `mem_ready`.
- It returns read data with a one-cycle ack, bounds CPU starvation of the debug port, and aborts accesses that hang.

Parameters:
- MAX_CPU_BURST, 4, consecutive CPU grants allowed while dbg_req is pending before debug wins a tie (0 = debug always wins ties)
- TIMEOUT, 64, cycles in an access state without mem_ready before abort (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  CPU write enable (1 = write)
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_stall  out  1  combinational, cpu_req & ~cpu_ack; freezes the controller FSM
- dbg_req  in  1  debug access request, held until dbg_ack
- dbg_we  in  1  debug write enable
- dbg_addr  in  32  debug byte address
- dbg_wdata  in  32  debug write data
- dbg_rdata  out  32  debug read data, valid with dbg_ack
- dbg_ack  out  1  one-cycle completion pulse to debug
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- err  out  1  one-cycle pulse coincident with an ack caused by timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, burst_cnt=0, wait_cnt=0.
  - All outputs 0, except cpu_stall, which follows cpu_req.
  - A transaction in flight is abandoned; no ack is issued for it.
- States and flags:
  - States are IDLE, CPU, DBG.
  - mem_req=1 exactly when the state is CPU or DBG.
  - All outputs except cpu_stall are registered.
- IDLE arbitration, decided on the current cycle's req inputs:
  - Only cpu_req: go to CPU.
  - Only dbg_req: go to DBG.
  - Both: if burst_cnt==MAX_CPU_BURST, go to DBG; otherwise go to CPU and increment burst_cnt (saturating).
  - A DBG grant clears burst_cnt.
  - A CPU grant with dbg_req=0 also clears burst_cnt.
- On grant (same edge):
  - mem_we, mem_addr, mem_wdata load from the winner's inputs.
  - These hold constant for the whole access.
  - Changes on the requester's inputs during the access are ignored.
- In CPU/DBG, on an edge with mem_ready=1:
  - The owner's rdata register loads mem_rdata; loaded on writes too, value is don't-care.
  - The owner's ack is set for one cycle.
  - State returns to IDLE; mem_req drops; wait_cnt clears.
  - The other port's rdata is unchanged.
- In CPU/DBG, on an edge with mem_ready=0:
  - wait_cnt increments.
  - When wait_cnt reaches TIMEOUT-1 with mem_ready still 0, the access aborts:
    - return to IDLE;
    - owner's ack=1 and err=1 for one cycle;
    - rdata is not updated.
- Latency:
  - If req rises in IDLE at cycle 0 and the memory is zero-wait (mem_ready=1 in cycle 1), ack is high in cycle 2.
  - In general, ack arrives 1 cycle after the mem_ready edge.
- Ack cycle:
  - The FSM is in IDLE and arbitrates normally.
  - A requester still asserting req in its ack cycle is treated as issuing a new request.
  - Requesters drop req in the ack cycle unless a back-to-back access is intended.
- Ties and pre-emption:
  - Simultaneous cpu_req and dbg_req in IDLE are resolved only by the burst rule above.
  - There is no pre-emption of an access in progress.
- A req deasserted while that requester owns the access does not cancel it; the ack still fires.

Test Plan:
- Zero-wait memory (mem_ready tied 1); CPU read at 0x00000010 returning 0x12345678 -> mem_req high in cycle 1, cpu_ack and cpu_rdata=0x12345678 in cycle 2, cpu_stall high cycles 0-1.
- dbg write 0x0000_0040 <- 0xCAFEBABE with 3-cycle memory latency -> mem_we=1, address and data stable for 3 cycles, dbg_ack one cycle after mem_ready, cpu_ack never set.
- cpu_req and dbg_req held continuously, MAX_CPU_BURST=4, zero-wait -> grant order CPU, CPU, CPU, CPU, DBG, repeating; with MAX_CPU_BURST=0 -> DBG wins every tie.
- TIMEOUT=8, mem_ready held 0 after a CPU grant -> 8 cycles in CPU, then cpu_ack=1 and err=1 in the same cycle, cpu_rdata unchanged, state back to IDLE.
- Reset asserted while in DBG mid-wait -> mem_req=0 immediately (asynchronous), no dbg_ack after release; a fresh cpu_req after release is granted normally, with burst_cnt starting at 0.
